// File: rtl/flow_control_credit_if.sv
// Allocator/FIFO-side handshake bundle for the credit flow-control block.
// master = allocator and input FIFOs, slave = flow-control logic.
interface flow_control_credit_if #(
    parameter int NPORT = 4,
    parameter int SEL_W = 3,
    parameter int CNT_W = 3
);
    logic [NPORT*SEL_W-1:0] out_sw;
    logic [NPORT-1:0]       out_req;
    logic [NPORT-1:0]       full;
    logic [NPORT-1:0]       credit_in;
    logic [NPORT-1:0]       valid;
    logic [NPORT-1:0]       empty;
    logic [NPORT-1:0]       en;
    logic [NPORT-1:0]       en_fifo;
    logic [NPORT-1:0]       send;
    logic [NPORT*CNT_W-1:0] credit_cnt;
    logic [NPORT-1:0]       credit_ovf;
    logic                   sel_conflict;

    modport master (
        output out_sw, out_req, full, credit_in, valid, empty,
        input  en, en_fifo, send, credit_cnt, credit_ovf, sel_conflict
    );

    modport slave (
        input  out_sw, out_req, full, credit_in, valid, empty,
        output en, en_fifo, send, credit_cnt, credit_ovf, sel_conflict
    );
endinterface

// File: rtl/flow_control_credit.sv
// Per-output credit (or legacy full-flag) backpressure for an NPORT router:
// combinational input/FIFO enables, registered credit counters and sticky errors.
module flow_control_credit #(
    parameter int NPORT       = 4,
    parameter int SEL_W       = 3,
    parameter int CREDITS     = 4,
    parameter int CNT_W       = 3,
    parameter int CREDIT_MODE = 1
) (
    input logic                  clk,
    input logic                  rst,
    flow_control_credit_if.slave fc
);

    logic [NPORT-1:0] ok;
    logic [NPORT-1:0] send_int;
    logic [NPORT-1:0] route [NPORT];   // route[o][i]: output o requests input i
    logic [NPORT-1:0] grant_in;
    logic [NPORT-1:0] en_int;
    logic             conflict_hit;
    logic             conflict_reg;
    logic             conflict_next;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_out
            logic [SEL_W-1:0] sel;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             ovf_reg;
            logic             ovf_next;

            assign sel = fc.out_sw[gi*SEL_W +: SEL_W];

            // Select values >= NPORT decode to no route, hence no grant and no send.
            for (gj = 0; gj < NPORT; gj++) begin : g_dec
                assign route[gi][gj] = fc.out_req[gi] && (sel == SEL_W'(gj));
            end

            assign ok[gi]       = (CREDIT_MODE != 0) ? (cnt_reg != '0) : !fc.full[gi];
            assign send_int[gi] = ok[gi] && (|(route[gi] & fc.valid));

            always_comb begin
                cnt_next = cnt_reg;
                ovf_next = ovf_reg;
                if (CREDIT_MODE != 0) begin
                    if (send_int[gi] && !fc.credit_in[gi]) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end else if (!send_int[gi] && fc.credit_in[gi]) begin
                        if (cnt_reg == CNT_W'(CREDITS)) begin
                            ovf_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= CNT_W'(CREDITS);
                    ovf_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    ovf_reg <= ovf_next;
                end
            end

            assign fc.credit_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
            assign fc.credit_ovf[gi]                = ovf_reg;
            assign fc.send[gi]                      = !rst && send_int[gi];
        end
    endgenerate

    always_comb begin
        grant_in = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (route[o][i] && ok[o]) begin
                    grant_in[i] = 1'b1;
                end
            end
        end
    end

    // Idle inputs stay enabled so an empty head never stalls the FIFO pop path.
    assign en_int     = rst ? '0 : (~fc.valid | grant_in);
    assign fc.en      = en_int;
    assign fc.en_fifo = en_int & ~fc.empty;

    always_comb begin
        conflict_hit = 1'b0;
        for (int o1 = 0; o1 < NPORT; o1++) begin
            for (int o2 = o1 + 1; o2 < NPORT; o2++) begin
                if (|(route[o1] & route[o2])) begin
                    conflict_hit = 1'b1;
                end
            end
        end
        conflict_next = conflict_reg | conflict_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= conflict_next;
        end
    end

    assign fc.sel_conflict = conflict_reg;

endmodule

// File: tb/tb_flow_control_credit.sv
// Drives a credit-mode and a legacy-mode instance with identical stimulus and
// compares both against an arithmetic reference model every cycle.
module tb_flow_control_credit;
    localparam int NPORT   = 4;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 3;
    localparam int CREDITS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flow_control_credit_if #(.NPORT(NPORT), .SEL_W(SEL_W), .CNT_W(CNT_W)) fc1 ();
    flow_control_credit_if #(.NPORT(NPORT), .SEL_W(SEL_W), .CNT_W(CNT_W)) fc0 ();

    flow_control_credit #(.NPORT(NPORT), .SEL_W(SEL_W), .CREDITS(CREDITS),
                          .CNT_W(CNT_W), .CREDIT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .fc(fc1));

    flow_control_credit #(.NPORT(NPORT), .SEL_W(SEL_W), .CREDITS(CREDITS),
                          .CNT_W(CNT_W), .CREDIT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .fc(fc0));

    int               sw [NPORT];
    logic [NPORT-1:0] req, full, cr, vld, emp;

    int               m_cnt  [2][NPORT];
    bit               m_ovf  [2][NPORT];
    bit               m_conf [2];
    logic [NPORT-1:0] x_send [2];
    logic [NPORT-1:0] x_en   [2];
    logic [NPORT-1:0] x_fifo [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int m, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (mode %0d): observed %0h expected %0h", tag, m, obs, exp);
        end
    endtask

    task automatic drive();
        logic [NPORT*SEL_W-1:0] p;
        p = '0;
        for (int o = 0; o < NPORT; o++) p[o*SEL_W +: SEL_W] = sw[o][SEL_W-1:0];
        fc1.out_sw = p;    fc0.out_sw = p;
        fc1.out_req = req; fc0.out_req = req;
        fc1.full = full;   fc0.full = full;
        fc1.credit_in = cr; fc0.credit_in = cr;
        fc1.valid = vld;   fc0.valid = vld;
        fc1.empty = emp;   fc0.empty = emp;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_conf[m] = 1'b0;
            for (int o = 0; o < NPORT; o++) begin
                m_cnt[m][o] = CREDITS;
                m_ovf[m][o] = 1'b0;
            end
        end
    endtask

    task automatic compute_expected();
        for (int m = 0; m < 2; m++) begin
            logic [NPORT-1:0] granted;
            granted   = '0;
            x_send[m] = '0;
            for (int o = 0; o < NPORT; o++) begin
                bit ready;
                ready = (m == 1) ? (m_cnt[m][o] > 0) : !full[o];
                if (req[o] && ready && sw[o] < NPORT) begin
                    granted[sw[o]] = 1'b1;
                    if (vld[sw[o]] && !rst) x_send[m][o] = 1'b1;
                end
            end
            for (int i = 0; i < NPORT; i++) begin
                x_en[m][i]   = !rst && (!vld[i] || granted[i]);
                x_fifo[m][i] = x_en[m][i] && !emp[i];
            end
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_conf[m] = 1'b0;
                for (int o = 0; o < NPORT; o++) begin
                    m_cnt[m][o] = CREDITS;
                    m_ovf[m][o] = 1'b0;
                end
            end else begin
                for (int a = 0; a < NPORT; a++)
                    for (int b = a + 1; b < NPORT; b++)
                        if (req[a] && req[b] && sw[a] == sw[b] && sw[a] < NPORT)
                            m_conf[m] = 1'b1;
                if (m == 1) begin
                    for (int o = 0; o < NPORT; o++) begin
                        if (x_send[m][o] && !cr[o]) m_cnt[m][o] = m_cnt[m][o] - 1;
                        else if (!x_send[m][o] && cr[o]) begin
                            if (m_cnt[m][o] < CREDITS) m_cnt[m][o] = m_cnt[m][o] + 1;
                            else m_ovf[m][o] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model at the rising edge.
    task automatic tick(input string tag);
        @(negedge clk);
        compute_expected();
        for (int m = 0; m < 2; m++) begin
            logic [NPORT*CNT_W-1:0] pc;
            logic [NPORT-1:0]       po;
            pc = '0;
            po = '0;
            for (int o = 0; o < NPORT; o++) begin
                pc[o*CNT_W +: CNT_W] = m_cnt[m][o][CNT_W-1:0];
                po[o]                = m_ovf[m][o];
            end
            if (m == 1) begin
                chk({tag, ":en"}, m, 32'(fc1.en), 32'(x_en[m]));
                chk({tag, ":en_fifo"}, m, 32'(fc1.en_fifo), 32'(x_fifo[m]));
                chk({tag, ":send"}, m, 32'(fc1.send), 32'(x_send[m]));
                chk({tag, ":credit_cnt"}, m, 32'(fc1.credit_cnt), 32'(pc));
                chk({tag, ":credit_ovf"}, m, 32'(fc1.credit_ovf), 32'(po));
                chk({tag, ":sel_conflict"}, m, 32'(fc1.sel_conflict), 32'(m_conf[m]));
            end else begin
                chk({tag, ":en"}, m, 32'(fc0.en), 32'(x_en[m]));
                chk({tag, ":en_fifo"}, m, 32'(fc0.en_fifo), 32'(x_fifo[m]));
                chk({tag, ":send"}, m, 32'(fc0.send), 32'(x_send[m]));
                chk({tag, ":credit_cnt"}, m, 32'(fc0.credit_cnt), 32'(pc));
                chk({tag, ":credit_ovf"}, m, 32'(fc0.credit_ovf), 32'(po));
                chk({tag, ":sel_conflict"}, m, 32'(fc0.sel_conflict), 32'(m_conf[m]));
            end
        end
        $display("[%0t] %s rst=%b req=%b vld=%b cr=%b full=%b | m1 send=%b cnt=%h | m0 send=%b",
                 $time, tag, rst, req, vld, cr, full, fc1.send, fc1.credit_cnt, fc0.send);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0; full = '0; cr = '0; vld = '0; emp = '1;
        for (int o = 0; o < NPORT; o++) sw[o] = 0;
        drive();
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_cnt", 1, 32'(fc1.credit_cnt), 32'h924);
        chk("rst_en", 1, 32'(fc1.en), 32'h0);
        tick("reset0");
        tick("reset1");

        rst = 1'b0;
        drive();
        #1;
        chk("idle_en", 1, 32'(fc1.en), 32'hF);
        tick("idle");

        // Drain output 1 from input 0 with no credits returned.
        sw[1] = 0; req[1] = 1'b1; vld[0] = 1'b1; emp[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive();
            #1;
            chk("drain_send1", 1, 32'(fc1.send[1]), 32'h1);
            tick("drain");
            chk("drain_cnt1", 1, 32'(fc1.credit_cnt[5:3]), 32'(4 - k));
        end
        chk("drain_en0", 1, 32'(fc1.en[0]), 32'h0);
        chk("drain_fifo0", 1, 32'(fc1.en_fifo[0]), 32'h0);
        chk("drain_send1_blk", 1, 32'(fc1.send[1]), 32'h0);
        tick("drain5");

        // Credit return at zero, then send plus simultaneous credit.
        cr[1] = 1'b1;
        drive();
        tick("ret");
        chk("ret_cnt1", 1, 32'(fc1.credit_cnt[5:3]), 32'h1);
        chk("ret_send1", 1, 32'(fc1.send[1]), 32'h1);
        tick("ret_both");
        chk("both_cnt1", 1, 32'(fc1.credit_cnt[5:3]), 32'h1);
        cr = '0;
        req = '0;

        // Overflow on an idle full-credit output.
        cr[2] = 1'b1;
        drive();
        tick("ovf");
        chk("ovf_cnt2", 1, 32'(fc1.credit_cnt[8:6]), 32'h4);
        chk("ovf_flag2", 1, 32'(fc1.credit_ovf[2]), 32'h1);
        cr = '0;
        drive();
        tick("ovf_hold");
        chk("ovf_sticky2", 1, 32'(fc1.credit_ovf[2]), 32'h1);

        // Two outputs selecting one input, then an out-of-range select.
        sw[0] = 1; sw[1] = 1; req = 4'b0011; vld = 4'b0010;
        drive();
        tick("conflict");
        chk("conflict_flag", 1, 32'(fc1.sel_conflict), 32'h1);
        sw[2] = 7; req[2] = 1'b1;
        drive();
        #1;
        chk("oor_send2", 1, 32'(fc1.send[2]), 32'h0);
        tick("oor");
        chk("conflict_sticky", 1, 32'(fc1.sel_conflict), 32'h1);

        // Legacy full-flag backpressure.
        req = 4'b1000; sw[3] = 2; vld = 4'b0100; emp = '0;
        for (int r = 0; r < 4; r++) begin
            full[3] = (r % 2 == 0);
            drive();
            #1;
            chk("legacy_en2", 0, 32'(fc0.en[2]), 32'(!full[3]));
            chk("legacy_send3", 0, 32'(fc0.send[3]), 32'(!full[3]));
            tick("legacy");
            chk("legacy_cnt", 0, 32'(fc0.credit_cnt), 32'h924);
        end

        rst = 1'b1; full = '0; req = '0;
        drive();
        tick("reset2");
        chk("rst2_ovf", 1, 32'(fc1.credit_ovf), 32'h0);
        chk("rst2_conf", 1, 32'(fc1.sel_conflict), 32'h0);
        rst = 1'b0;

        // Randomised traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int o = 0; o < NPORT; o++) begin
                sw[o]   = $urandom_range(0, 7);
                cr[o]   = ($urandom_range(0, 3) == 0);
            end
            req  = NPORT'($urandom);
            full = NPORT'($urandom);
            vld  = NPORT'($urandom);
            emp  = NPORT'($urandom);
            drive();
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
